uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data-memory port, directly downstream of the load/store path.
- Consumes the word address, write data, byte mask and MemWrite/MemRead strobes that the control unit produces.
- Returns read data for the data-memory read mux.
- Buffers bytes in a TX FIFO and serialises them 8N1 on a single tx pin at a programmable bit period.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of 16-byte register window; bits [3:0] must be 0.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2, at most 128.
- DEFAULT_DIV, 16'd434, reset value of bit-period register, in clk cycles (50 MHz / 115200).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- addr  input  32  byte address from load/store unit
- data_wr  input  32  store data, lane-aligned
- mask  input  4  byte-enable mask for stores
- mem_write  input  1  store strobe (MemWrite)
- mem_read  input  1  load strobe (MemRead)
- sel  output  1  address hits register window; top uses it to steer the data-memory mux
- rd_data  output  32  read data; 0 when not selected
- tx  output  1  serial line, idle high

Behaviour:
Reset and addressing:
- One clock, synchronous active-low reset.
- While rst_n=0 at a clk edge: FIFO emptied, FSM to IDLE, tx=1, div=DEFAULT_DIV, overflow=0.
- Reset mid-frame aborts the frame; tx is high from the next edge.
- sel = (addr[31:4] == BASE_ADDR[31:4]), combinational.
- Register offsets, addr[3:2]:
  - 0x0 TXDATA
  - 0x4 STATUS
  - 0x8 DIV
  - 0xC reserved: reads 0, writes ignored.

Reads:
- rd_data is combinational, same cycle, gated by sel & mem_read; otherwise 0.
- Reads have no side effects.
- TXDATA reads 0.
- STATUS: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] overflow (sticky), [15:8] FIFO count, other bits 0.
- DIV reads {16'b0, div}.

Writes (all registered, on clk edge when sel & mem_write):
- TXDATA:
  - Requires mask[0]; pushes data_wr[7:0].
  - If FIFO is full and no pop occurs in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle on a full FIFO: push accepted, count unchanged.
- STATUS: writing 1 to data_wr[3] with mask[0] clears overflow; other bits read-only.
- DIV:
  - Byte lanes 0/1 honoured per mask.
  - A resulting value of 0 is stored as 1.
  - A write while busy does not affect the frame in progress; div is latched into the bit timer at each frame start.

Transmit FSM (states IDLE, START, DATA, STOP); bit counter 16-bit, bit index 3-bit:
- IDLE:
  - tx=1.
  - If FIFO non-empty: pop head into shift register, latch div, go to START.
  - A byte pushed at edge N is popped at edge N+1; tx=0 from edge N+1.
- START: tx=0 for div cycles, then DATA.
- DATA: tx=shift[0], LSB first, each bit div cycles; after bit 7 go to STOP.
- STOP: tx=1 for div cycles, then IDLE.
- Timing consequences:
  - One frame = 10*div cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle.
- FIFO:
  - Circular with wrap-around read/write pointers and a count register (0..FIFO_DEPTH).
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Pointer wrap at FIFO_DEPTH-1 → 0.
- mem_read and mem_write asserted together: the write is performed at the edge; read data reflects pre-edge state.

Test Plan:
1. Reset, then read STATUS and DIV → STATUS=0x0000_0002 (empty), DIV=434, tx=1 held.
2. Write DIV=4, write TXDATA=0xA5 at edge N → tx=0 over cycles N+1..N+4; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop=1; busy=1 for exactly 40 cycles, then STATUS=0x2.
3. DIV=2, write 9 bytes 0x00..0x08 back-to-back → STATUS count=8 and full=1 after the 9th write with overflow=0 (one byte already popped); with DIV=100, 10 writes → overflow=1, the 10th byte never transmitted; write STATUS bit3=1 → overflow=0.
4. DIV=3, write 0x55, 0x0F → two frames of 30 cycles each, one idle-high cycle between them, bytes in order.
5. Write DIV=8 mid-frame while DIV=4 → current frame keeps 4-cycle bits; next frame uses 8; write DIV=0 → reads back 1.
6. Assert rst_n=0 during DATA bit 3 → tx=1 and STATUS=0x2 after that edge; addr=0x1000_0010 store → sel=0, no push; TXDATA write with mask=4'b0010 → ignored.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core's data-memory port.
// Stores to TXDATA queue bytes in a small circular FIFO. An IDLE/START/DATA/STOP
// FSM serialises each byte LSB first at a programmable bit period (DIV).
// STATUS and DIV read back combinationally in the same cycle.

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        sel,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;

  logic [15:0]      div;
  logic [15:0]      div_wr_val;
  logic [15:0]      bit_div;
  logic [15:0]      bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done;
  logic             busy;

  logic [1:0]       reg_off;
  logic             wr_txdata;
  logic             wr_status_clr;
  logic             wr_div;
  logic             pop;
  logic             push;
  logic             drop;

  // Address bits below the word, the upper data lanes and the upper mask
  // lanes carry no meaning for this peripheral.
  logic             unused_bits;
  assign unused_bits = ^{addr[1:0], data_wr[31:16], mask[3:2]};

  assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off = addr[3:2];

  assign wr_txdata     = sel & mem_write & (reg_off == 2'd0) & mask[0];
  assign wr_status_clr = sel & mem_write & (reg_off == 2'd1) & mask[0] & data_wr[3];
  assign wr_div        = sel & mem_write & (reg_off == 2'd2);

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign busy  = (state != IDLE);

  // A byte leaves the FIFO only when the transmitter is idle. A push into a
  // full FIFO still succeeds if that same edge frees a slot.
  assign pop  = (state == IDLE) & ~empty;
  assign push = wr_txdata & (~full | pop);
  assign drop = wr_txdata & full & ~pop;

  assign bit_done = (bit_cnt == bit_div - 16'd1);

  assign div_wr_val = {mask[1] ? data_wr[15:8] : div[15:8],
                       mask[0] ? data_wr[7:0]  : div[7:0]};

  // Combinational read mux; reads never alter state.
  always_comb begin
    rd_data = '0;
    if (sel && mem_read) begin
      case (reg_off)
        2'd1:    rd_data = {16'b0, 8'(count), 4'b0, overflow, busy, empty, full};
        2'd2:    rd_data = {16'b0, div};
        default: rd_data = '0;
      endcase
    end
  end

  // FIFO storage; its contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_wr[7:0];
    end
  end

  // FIFO pointers and occupancy count, wrapping explicitly at the last entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Control registers: sticky overflow flag and bit period (zero coerced to 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_status_clr) begin
        overflow <= 1'b0;
      end
      if (wr_div) begin
        div <= (div_wr_val == 16'd0) ? 16'd1 : div_wr_val;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and the serial line value decoded from the current state.
  always_comb begin
    state_nx = state;
    tx       = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nx = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_done && (bit_idx == 3'd7)) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timer and shifter. The divider is latched at frame start so a DIV
  // write during a frame only affects the following frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      bit_div <= DEFAULT_DIV;
    end else if (pop) begin
      shift   <= fifo_mem[rd_ptr];
      bit_div <= div;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        bit_cnt <= '0;
        if (state == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        bit_cnt <= bit_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio. A reference model keeps
// the FIFO as a queue and the transmitter as a frame position counter; the
// expected tx level is derived from that position and the bit period.

module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  mask = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        sel;
  logic [31:0] rd_data;
  logic        tx;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] mq[$];
  int         m_div = 434;
  bit         m_ovf = 1'b0;
  int         m_rem = 0;
  int         m_pos = 0;
  int         m_cdiv = 1;
  logic [7:0] m_cur = '0;

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_wr  (data_wr),
    .mask     (mask),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .sel      (sel),
    .rd_data  (rd_data),
    .tx       (tx)
  );

  // 100 MHz-style clock.
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    bit          do_pop;
    int          old_div;
    logic [15:0] nd;
    if (!rst_n) begin
      mq.delete();
      m_div = 434;
      m_ovf = 1'b0;
      m_rem = 0;
      m_pos = 0;
      return;
    end
    old_div = m_div;
    do_pop  = (m_rem == 0) && (mq.size() > 0);
    if (do_pop) m_cur = mq.pop_front();
    if ((addr[31:4] == BASE[31:4]) && mem_write) begin
      case (addr[3:2])
        2'd0: if (mask[0]) begin
          if (mq.size() < DEPTH) mq.push_back(data_wr[7:0]);
          else m_ovf = 1'b1;
        end
        2'd1: if (mask[0] && data_wr[3]) m_ovf = 1'b0;
        2'd2: begin
          nd = 16'(m_div);
          if (mask[0]) nd[7:0] = data_wr[7:0];
          if (mask[1]) nd[15:8] = data_wr[15:8];
          m_div = (nd == 16'd0) ? 1 : int'(nd);
        end
        default: ;
      endcase
    end
    if (do_pop) begin
      m_rem  = 10 * old_div;
      m_pos  = 0;
      m_cdiv = old_div;
    end else if (m_rem > 0) begin
      m_rem--;
      m_pos++;
    end
  endfunction

  function automatic logic model_tx();
    int b;
    if (m_rem == 0) return 1'b1;
    b = m_pos / m_cdiv;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    int          n = mq.size();
    s[0]    = (n == DEPTH);
    s[1]    = (n == 0);
    s[2]    = (m_rem != 0);
    s[3]    = m_ovf;
    s[15:8] = 8'(n);
    return s;
  endfunction

  function automatic logic [31:0] model_rd();
    if (!(mem_read && (addr[31:4] == BASE[31:4]))) return '0;
    case (addr[3:2])
      2'd1:    return model_status();
      2'd2:    return {16'b0, 16'(m_div)};
      default: return '0;
    endcase
  endfunction

  function automatic bit model_idle();
    return (m_rem == 0) && (mq.size() == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; data_wr = d; mask = m; mem_write = 1'b1; mem_read = 1'b0;
    tick();
    mem_write = 1'b0; addr = '0; mask = '0; data_wr = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    d = rd_data;
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int          tx_bad = 0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h2); end
    bus_read(BASE + 32'h8, v);
    checks++;
    if (v !== 32'd434) begin errors++; $display("[TB] FAIL reset_div: got %0d expected 434", v); end
    bus_read(BASE + 32'hC, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("[TB] FAIL reserved_read: got %h expected 0", v); end
    bus_read(BASE, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected 0", v); end
    addr = BASE + 32'h4;
    #1;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("[TB] FAIL sel_hit: got %b expected 1", sel); end
    addr = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (tx !== 1'b1) tx_bad++;
    end
    checks++;
    if (tx_bad != 0) begin errors++; $display("[TB] FAIL reset_idle_tx: got %0d low cycles expected 0", tx_bad); end
  endtask

  task automatic test_single_frame();
    logic [9:0]  pat = {1'b1, 8'hA5, 1'b0};
    logic [31:0] v;
    logic        exp_tx;
    int          pat_bad = 0;
    int          mdl_bad = 0;
    int          busy_cnt = 0;
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, 32'h0000_00A5, 4'b0001);
    for (int k = 1; k <= 44; k++) begin
      tick();
      exp_tx = (k <= 40) ? pat[(k-1)/4] : 1'b1;
      if (tx !== exp_tx) pat_bad++;
      if (tx !== model_tx()) mdl_bad++;
      bus_read(BASE + 32'h4, v);
      if (v[2] === 1'b1) busy_cnt++;
    end
    checks++;
    if (pat_bad != 0) begin errors++; $display("[TB] FAIL frame_a5_wave: got %0d bad cycles expected 0", pat_bad); end
    checks++;
    if (mdl_bad != 0) begin errors++; $display("[TB] FAIL frame_a5_model: got %0d bad cycles expected 0", mdl_bad); end
    checks++;
    if (busy_cnt != 40) begin errors++; $display("[TB] FAIL frame_a5_busy: got %0d cycles expected 40", busy_cnt); end
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("[TB] FAIL frame_a5_status: got %h expected 2", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int          tx_bad = 0;
    int          guard = 0;
    bus_write(BASE + 32'h8, 32'd2, 4'b0011);
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'(i), 4'b0001);
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0805) begin errors++; $display("[TB] FAIL fill_status: got %h expected %h", v, 32'h805); end
    while (!model_idle() && guard < 400) begin
      tick();
      guard++;
      if (tx !== model_tx()) tx_bad++;
    end
    checks++;
    if (guard >= 400 || tx_bad != 0) begin errors++; $display("[TB] FAIL fill_drain: got %0d bad cycles (%0d waited) expected 0", tx_bad, guard); end
    bus_write(BASE + 32'h8, 32'd100, 4'b0011);
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'($urandom_range(0, 255)), 4'b0001);
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_080D) begin errors++; $display("[TB] FAIL ovf_status: got %h expected %h", v, 32'h80D); end
    bus_write(BASE + 32'h4, 32'h0000_0008, 4'b0001);
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0805) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected %h", v, 32'h805); end
    tx_bad = 0;
    guard = 0;
    while (!model_idle() && guard < 10000) begin
      tick();
      guard++;
      if (tx !== model_tx()) tx_bad++;
    end
    checks++;
    if (guard >= 10000 || tx_bad != 0) begin errors++; $display("[TB] FAIL ovf_drain: got %0d bad cycles (%0d waited) expected 0", tx_bad, guard); end
    tick();
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("[TB] FAIL ovf_final_status: got %h expected 2", v); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  pat1 = {1'b1, 8'h55, 1'b0};
    logic [9:0]  pat2 = {1'b1, 8'h0F, 1'b0};
    logic [31:0] v;
    logic        exp_tx;
    logic        exp_busy;
    int          wave_bad = 0;
    int          busy_bad = 0;
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    bus_write(BASE, 32'h55, 4'b0001);
    bus_write(BASE, 32'h0F, 4'b0001);
    for (int k = 0; k < 70; k++) begin
      if (k > 0) tick();
      if (k < 30) begin exp_tx = pat1[k/3]; exp_busy = 1'b1; end
      else if (k == 30) begin exp_tx = 1'b1; exp_busy = 1'b0; end
      else if (k <= 60) begin exp_tx = pat2[(k-31)/3]; exp_busy = 1'b1; end
      else begin exp_tx = 1'b1; exp_busy = 1'b0; end
      if (tx !== exp_tx) wave_bad++;
      bus_read(BASE + 32'h4, v);
      if (v[2] !== exp_busy) busy_bad++;
    end
    checks++;
    if (wave_bad != 0) begin errors++; $display("[TB] FAIL b2b_wave: got %0d bad cycles expected 0", wave_bad); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("[TB] FAIL b2b_busy: got %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_div_midframe();
    logic [31:0] v;
    int          runs[$];
    int          cur_run = 0;
    int          tx_bad = 0;
    int          r0;
    int          r1;
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, 32'($urandom_range(0, 255)), 4'b0001);
    bus_write(BASE, 32'($urandom_range(0, 255)), 4'b0001);
    for (int k = 0; k < 130; k++) begin
      if (k > 0) begin
        if (k == 10) begin
          addr = BASE + 32'h8; data_wr = 32'd8; mask = 4'b0011; mem_write = 1'b1;
        end
        tick();
        mem_write = 1'b0; mask = '0; data_wr = '0;
      end
      if (tx !== model_tx()) tx_bad++;
      bus_read(BASE + 32'h4, v);
      if (v[2] === 1'b1) cur_run++;
      else if (cur_run > 0) begin runs.push_back(cur_run); cur_run = 0; end
    end
    if (cur_run > 0) runs.push_back(cur_run);
    r0 = (runs.size() > 0) ? runs[0] : -1;
    r1 = (runs.size() > 1) ? runs[1] : -1;
    checks++;
    if (tx_bad != 0) begin errors++; $display("[TB] FAIL div_mid_model: got %0d bad cycles expected 0", tx_bad); end
    checks++;
    if (r0 != 40) begin errors++; $display("[TB] FAIL div_mid_frame1: got %0d cycles expected 40", r0); end
    checks++;
    if (r1 != 80) begin errors++; $display("[TB] FAIL div_mid_frame2: got %0d cycles expected 80", r1); end
    bus_write(BASE + 32'h8, 32'd0, 4'b0011);
    bus_read(BASE + 32'h8, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("[TB] FAIL div_zero: got %0d expected 1", v); end
    bus_write(BASE + 32'h8, 32'h0000_0300, 4'b0010);
    bus_read(BASE + 32'h8, v);
    checks++;
    if (v !== 32'h0000_0301) begin errors++; $display("[TB] FAIL div_lane1: got %h expected %h", v, 32'h301); end
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'h8, v);
    checks++;
    if (v !== 32'h0000_0301) begin errors++; $display("[TB] FAIL reserved_write: got %h expected %h", v, 32'h301); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int          guard = 0;
    int          tx_bad = 0;
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, 32'hA5, 4'b0001);
    while (!(m_rem > 0 && m_pos == 17) && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 100 || tx !== 1'b0) begin errors++; $display("[TB] FAIL data_bit3: got %b (%0d waited) expected 0", tx, guard); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL abort_tx: got %b expected 1", tx); end
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("[TB] FAIL abort_status: got %h expected 2", v); end
    bus_read(BASE + 32'h8, v);
    checks++;
    if (v !== 32'd434) begin errors++; $display("[TB] FAIL abort_div: got %0d expected 434", v); end
    rst_n = 1'b1;
    tick();
    addr = BASE + 32'h10; data_wr = 32'h77; mask = 4'hF; mem_write = 1'b1; mem_read = 1'b1;
    #1;
    checks++;
    if (sel !== 1'b0) begin errors++; $display("[TB] FAIL miss_sel: got %b expected 0", sel); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL miss_rd: got %h expected 0", rd_data); end
    tick();
    mem_write = 1'b0; mem_read = 1'b0; mask = '0; addr = '0;
    bus_write(BASE, 32'h0000_3C3C, 4'b0010);
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_0002) begin errors++; $display("[TB] FAIL no_push_status: got %h expected 2", v); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (tx !== 1'b1) tx_bad++;
    end
    checks++;
    if (tx_bad != 0) begin errors++; $display("[TB] FAIL no_push_tx: got %0d low cycles expected 0", tx_bad); end
  endtask

  task automatic test_random();
    int          tx_bad = 0;
    int          rd_bad = 0;
    int          sel_bad = 0;
    int          guard = 0;
    int          r;
    logic [31:0] v;
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    for (int c = 0; c < 3000; c++) begin
      r         = $urandom_range(0, 99);
      data_wr   = $urandom;
      mask      = 4'($urandom_range(0, 15));
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'b0;
      addr      = BASE + 32'($urandom_range(0, 3) * 4);
      if (r < 35) begin
        addr = BASE; mem_write = 1'b1;
        if (r < 30) mask[0] = 1'b1;
      end else if (r < 40) begin
        addr = BASE + 32'h8; data_wr = 32'($urandom_range(0, 4)); mask = 4'b0011; mem_write = 1'b1;
      end else if (r < 44) begin
        addr = BASE + 32'h4; mem_write = 1'b1;
      end else if (r < 47) begin
        addr = BASE + 32'hC; mem_write = 1'b1;
      end else if (r < 52) begin
        addr = BASE + 32'h10 + 32'($urandom_range(0, 15) * 4); mem_write = 1'b1;
      end
      #1;
      if (sel !== (addr[31:4] == BASE[31:4])) sel_bad++;
      if (rd_data !== model_rd()) rd_bad++;
      tick();
      if (tx !== model_tx()) tx_bad++;
    end
    mem_write = 1'b0; mem_read = 1'b0; mask = '0; addr = '0; data_wr = '0;
    while (!model_idle() && guard < 3000) begin
      tick();
      guard++;
      if (tx !== model_tx()) tx_bad++;
    end
    checks++;
    if (sel_bad != 0) begin errors++; $display("[TB] FAIL rand_sel: got %0d bad cycles expected 0", sel_bad); end
    checks++;
    if (rd_bad != 0) begin errors++; $display("[TB] FAIL rand_rd: got %0d bad reads expected 0", rd_bad); end
    checks++;
    if (guard >= 3000 || tx_bad != 0) begin errors++; $display("[TB] FAIL rand_tx: got %0d bad cycles (%0d waited) expected 0", tx_bad, guard); end
    bus_read(BASE + 32'h4, v);
    checks++;
    if (v !== model_status()) begin errors++; $display("[TB] FAIL rand_status: got %h expected %h", v, model_status()); end
  endtask

  // Main sequence.
  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_div_midframe();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
